// File: rtl/vram_arbiter_pkg.sv
// Shared encodings for the VRAM arbiter: FSM state codes, grant sources and
// the saturating wait-counter step.
package vram_arbiter_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_VID     = 3'd1;
  localparam logic [2:0] ST_CPU_RD  = 3'd2;
  localparam logic [2:0] ST_CPU_WR  = 3'd3;
  localparam logic [2:0] ST_CPU_RET = 3'd4;
  localparam logic [2:0] ST_CLR     = 3'd5;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_VID  = 2'd1,
    GNT_CPU  = 2'd2,
    GNT_CLR  = 2'd3
  } gnt_e;

  function automatic logic [3:0] wait_inc(input logic [3:0] w);
    return (w == 4'hF) ? w : w + 4'h1;
  endfunction

endpackage

// File: rtl/vram_arbiter_clear_counter.sv
// Clear engine for the VRAM arbiter: walks cells 0..CELLS-1 one write per
// granted idle slot, and holds busy until the cycle after the last write.
module vram_arbiter_clear_counter #(
  parameter int A     = 10,
  parameter int CELLS = 1000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr_start,
  input  logic         clr_adv,
  output logic         clr_req,
  output logic [A-1:0] clr_addr,
  output logic         clr_busy
);

  localparam logic [A:0] CNT_END = (A+1)'(CELLS);

  logic [A:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (clr_start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
    end else if (busy_q) begin
      // cnt reaching CNT_END means the final cell was written last cycle
      if (cnt_q == CNT_END) begin
        busy_d = 1'b0;
      end else if (clr_adv) begin
        cnt_d = cnt_q + (A+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign clr_req  = busy_q && (cnt_q != CNT_END);
  assign clr_addr = cnt_q[A-1:0];
  assign clr_busy = busy_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port character VRAM arbiter between video fetch, CPU bus and an
// optional clear engine (enabled with VRAM_CLEAR_EN).
//
// state      | meaning
// IDLE       | nothing issued this cycle
// VID        | video fetch issued to RAM
// CPU_RD     | CPU read issued to RAM
// CPU_WR     | CPU write issued, ack pulsing
// CPU_RET    | CPU read data returning from RAM, nothing new issued
// CLR        | clear engine write issued
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int           A            = 10,
  parameter int           D            = 8,
  parameter int           CELLS        = 1000,
  parameter int           CPU_MAX_WAIT = 3,
  parameter logic [D-1:0] FILL         = 8'h20
) (
  input  logic         clk,
  input  logic         reset_n,
`ifdef VRAM_CLEAR_EN
  input  logic         clr_start,
  output logic         clr_busy,
`endif
  input  logic         vid_req,
  input  logic [A-1:0] vid_addr,
  output logic [D-1:0] vid_data,
  output logic         vid_valid,
  output logic         vid_late,
  input  logic         cpu_req,
  input  logic         cpu_we,
  input  logic [A-1:0] cpu_addr,
  input  logic [D-1:0] cpu_wdata,
  output logic [D-1:0] cpu_rdata,
  output logic         cpu_ack,
  output logic [A-1:0] ram_addr,
  output logic         ram_we,
  output logic [D-1:0] ram_wdata,
  input  logic [D-1:0] ram_rdata
);

  localparam logic [3:0] MAX_WAIT = 4'(CPU_MAX_WAIT);

  logic [2:0]   state_q, state_d;
  logic         pend_q, pend_d;
  logic [A-1:0] pend_addr_q, pend_addr_d;
  logic [3:0]   wait_q, wait_d;
  logic         ret_vid_q, ret_vid_d;
  logic         ret_cpu_q, ret_cpu_d;
  logic [A-1:0] ram_addr_q, ram_addr_d;
  logic         ram_we_q, ram_we_d;
  logic [D-1:0] ram_wdata_q, ram_wdata_d;
  logic [D-1:0] vid_data_q, vid_data_d;
  logic         vid_valid_q, vid_valid_d;
  logic         vid_late_q, vid_late_d;
  logic [D-1:0] cpu_rdata_q, cpu_rdata_d;
  logic         cpu_ack_q, cpu_ack_d;

  gnt_e         gnt;
  logic         cpu_busy, cpu_elig, vid_new_gnt;
  logic         clr_req;
  logic [A-1:0] clr_addr;

`ifdef VRAM_CLEAR_EN
  logic clr_adv;
  assign clr_adv = (gnt == GNT_CLR);

  vram_arbiter_clear_counter #(
    .A     (A),
    .CELLS (CELLS)
  ) u_clear (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr_start (clr_start),
    .clr_adv   (clr_adv),
    .clr_req   (clr_req),
    .clr_addr  (clr_addr),
    .clr_busy  (clr_busy)
  );
`else
  assign clr_req  = 1'b0;
  assign clr_addr = '0;
`endif

  always_comb begin
    // A held cpu_req stays ineligible until its ack has been seen by the bus
    cpu_busy = (state_q == ST_CPU_RD) || ret_cpu_q || cpu_ack_q;
    cpu_elig = cpu_req && !cpu_busy;

    gnt = GNT_NONE;
    if (pend_q)                              gnt = GNT_VID;
    else if (cpu_elig && wait_q >= MAX_WAIT) gnt = GNT_CPU;
    else if (vid_req)                        gnt = GNT_VID;
    else if (cpu_elig)                       gnt = GNT_CPU;
    else if (clr_req)                        gnt = GNT_CLR;
    vid_new_gnt = (gnt == GNT_VID) && !pend_q;

    state_d     = ST_IDLE;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    wait_d      = wait_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    vid_data_d  = vid_data_q;
    vid_valid_d = 1'b0;
    vid_late_d  = vid_late_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ack_d   = 1'b0;

    if (vid_req && !vid_new_gnt) begin
      pend_d      = 1'b1;
      pend_addr_d = vid_addr;
      vid_late_d  = 1'b1;
    end else if (gnt == GNT_VID && pend_q) begin
      pend_d = 1'b0;
    end

    if (gnt == GNT_CPU)  wait_d = 4'h0;
    else if (cpu_elig)   wait_d = wait_inc(wait_q);

    case (gnt)
      GNT_VID: begin
        ram_addr_d = pend_q ? pend_addr_q : vid_addr;
        state_d    = ST_VID;
      end
      GNT_CPU: begin
        ram_addr_d  = cpu_addr;
        ram_we_d    = cpu_we;
        ram_wdata_d = cpu_wdata;
        cpu_ack_d   = cpu_we;
        state_d     = cpu_we ? ST_CPU_WR : ST_CPU_RD;
      end
      GNT_CLR: begin
        ram_addr_d  = clr_addr;
        ram_we_d    = 1'b1;
        ram_wdata_d = FILL;
        state_d     = ST_CLR;
      end
      default: state_d = (state_q == ST_CPU_RD) ? ST_CPU_RET : ST_IDLE;
    endcase

    ret_vid_d = (state_q == ST_VID);
    ret_cpu_d = (state_q == ST_CPU_RD);
    if (ret_vid_q) begin
      vid_data_d  = ram_rdata;
      vid_valid_d = 1'b1;
    end
    if (ret_cpu_q) begin
      cpu_rdata_d = ram_rdata;
      cpu_ack_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      wait_q      <= 4'h0;
      ret_vid_q   <= 1'b0;
      ret_cpu_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      vid_data_q  <= '0;
      vid_valid_q <= 1'b0;
      vid_late_q  <= 1'b0;
      cpu_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      wait_q      <= wait_d;
      ret_vid_q   <= ret_vid_d;
      ret_cpu_q   <= ret_cpu_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      vid_data_q  <= vid_data_d;
      vid_valid_q <= vid_valid_d;
      vid_late_q  <= vid_late_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;
  assign vid_data  = vid_data_q;
  assign vid_valid = vid_valid_q;
  assign vid_late  = vid_late_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ack   = cpu_ack_q;

endmodule
